line_buffer_ctrl: RTL and testbench
===================================

// Module: line_buffer_ctrl
// PURPOSE
// - Stage directly upstream of the multi-line SRAM. Turns a raster pixel stream into per-line
//   write/read strobes and column addresses for the SRAM.
// - Writes each pixel into the line slot currently being filled. Reads the same column from the
//   other LINES-1 slots.
// - Emits one vertical LINES-tall column per accepted pixel to the downstream stencil stage.
// PARAMETERS
// - WIDTH  1920             pixels per image row
// - BITS   16               bits per channel sample
// - CHAN   3                channels per pixel
// - LINES  3                SRAM line slots = stencil height
// - PORTS  2                SRAM ports per line; port 0 = write, port 1 = read
// - AW     $clog2(WIDTH)    column address width
// PORTS
// - clk        in   1                     single clock, rising edge
// - rst        in   1                     asynchronous, active-high reset
// - in_valid   in   1                     input pixel valid
// - in_ready   out  1                     input pixel accepted when in_valid & in_ready
// - in_sof     in   1                     start of frame, qualified by in_valid
// - in_data    in   CHAN*BITS             input pixel
// - sram_addr  out  [PORTS][AW] x LINES   to SRAM addr
// - sram_wen   out  [PORTS] x LINES       to SRAM wen
// - sram_ren   out  [PORTS] x LINES       to SRAM ren
// - sram_wdata out  CHAN*BITS             to SRAM Idata
// - sram_rdata in   CHAN*BITS x LINES x PORTS   from SRAM Odata; valid 1 cycle after ren
// - out_valid  out  1                     column valid
// - out_ready  in   1                     downstream accepts column
// - out_col    out  CHAN*BITS x LINES     [0] = oldest row ... [LINES-1] = current pixel
// - out_x      out  AW                    column index of out_col
// - out_err    out  1                     sticky error (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all counters 0, state FILL, wr_line 0.
//   Reset values: in_ready 0, out_valid 0, out_x 0, out_col 0, out_err 0, all wen/ren 0.
// - in_ready = !out_valid | out_ready, registered into the 1-deep output slot.
//   in_ready is 0 during reset.
// - Accept cycle:
//   - wen[wr_line][0]=1 and addr[wr_line][0]=col.
//   - ren[k][1]=1 and addr[k][1]=col for every k != wr_line.
//   - The pixel is delayed 1 cycle in a register to align with SRAM read data.
// - Latency: pixel accepted in cycle N -> out_valid=1 in cycle N+1.
//   out_col holds the SRAM read data of the other lines, reordered oldest-first by the rotation
//   of wr_line, plus the delayed pixel as entry LINES-1.
// - out_valid stays high with out_col/out_x stable until out_ready.
// - Column counter col: increments per accepted pixel. At WIDTH-1 it wraps to 0.
//   On wrap, wr_line advances modulo LINES and row_cnt increments.
// - FSM, 2 states:
//   - FILL: SRAM writes occur; out_valid is never asserted.
//     Exit to STREAM on the wrap that completes row LINES-2.
//   - STREAM: every accepted pixel yields a column.
// - in_sof with an accepted pixel: col=0, wr_line=0, row_cnt=0, state FILL.
//   The pixel itself is written at column 0.
//   An in_sof accepted mid-row discards the partial frame; no stale columns are emitted.
// - Simultaneous write and reads never target the same line slot, so there are no SRAM conflicts.
// - Reset mid-frame: the output slot is dropped; the next frame must start with in_sof.
// CONFIGURATION
// - Macro LB_SOF_CHECK_EN.
// - Defined: out_err is set, sticky until rst, when either:
//   - in_sof is accepted while col != 0, or
//   - a pixel arrives after reset before any in_sof (that pixel is dropped).
// - Undefined: out_err is tied to 0 and pre-SOF pixels are treated as row 0.
// TESTING
// - T1 WIDTH=4, LINES=3: stream 12 pixels of value p=row*16+col from in_sof.
//   Expect no out_valid for rows 0-1. Row 2 gives out_col = {p(0,x), p(1,x), p(2,x)}, out_x = 0..3.
// - T2 Backpressure: out_ready=0 for 5 cycles mid-row 2.
//   Expect in_ready=0, out_col stable, no SRAM strobes, and no lost or duplicated columns on release.
// - T3 Wrap rotation: run 5 rows. Row 4 gives out_col = {row2, row3, row4} values.
//   wen cycles through lines 0,1,2,0,1 per row.
// - T4 Mid-row in_sof at col 2 of row 3.
//   Expect state FILL, no out_valid for the next 2 rows, and out_err=1 when LB_SOF_CHECK_EN is
//   defined (0 when it is not).
// - T5 Assert rst for 1 cycle mid-row 2. Expect out_valid=0 and in_ready=0 immediately.
//   After release with in_sof, T1 results repeat exactly.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - raster pixel stream to multi-line SRAM strobes and stencil columns
//
// Purpose: writes each accepted pixel into the line slot being filled, reads the same
// column from the other LINES-1 slots, and presents one LINES-tall column per accepted
// pixel (oldest row first, current pixel last) through a 1-deep output slot.
// Optional feature macro: LB_SOF_CHECK_EN (sticky out_err on mid-row SOF or pre-SOF pixel).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input pixel handshake; in_sof marks frame start; in_data pixel
//   sram_addr/wen/ren   per line, per port (port 0 write, port 1 read)
//   sram_wdata          write data; sram_rdata read data, valid one cycle after ren
//   out_valid/out_ready column handshake; out_col [0]=oldest row .. [LINES-1]=current
//   out_x               column index of out_col
//   out_err             sticky framing error (0 when the check is not built)
module line_buffer_ctrl #(
  parameter int WIDTH = 1920,
  parameter int BITS  = 16,
  parameter int CHAN  = 3,
  parameter int LINES = 3,
  parameter int PORTS = 2,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic                                       in_sof,
  input  logic [CHAN*BITS-1:0]                       in_data,
  output logic [LINES-1:0][PORTS-1:0][AW-1:0]        sram_addr,
  output logic [LINES-1:0][PORTS-1:0]                sram_wen,
  output logic [LINES-1:0][PORTS-1:0]                sram_ren,
  output logic [CHAN*BITS-1:0]                       sram_wdata,
  input  logic [LINES-1:0][PORTS-1:0][CHAN*BITS-1:0] sram_rdata,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [LINES-1:0][CHAN*BITS-1:0]            out_col,
  output logic [AW-1:0]                              out_x,
  output logic                                       out_err
);

  localparam int DW = CHAN*BITS;
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic {FILL, STREAM} state_t;

  state_t                      state;
  logic [AW-1:0]               col;
  logic [LW-1:0]               wr_line;
  logic [LW-1:0]               row_cnt;
  logic                        rd_pending;
  logic [DW-1:0]               pix_d;
  logic [LW-1:0]               wl_d;
  logic [LINES-1:0][DW-1:0]    col_hold;

  logic                        accept;
  logic                        drop;
  logic                        wr_acc;
  logic                        emit;
  logic                        last_col;
  logic [AW-1:0]               eff_col;
  logic [LW-1:0]               eff_line;
  logic [LW-1:0]               eff_row;
  state_t                      eff_state;
  logic                        unused_rdata;

  // Line slot holding the j-th oldest row when wl is the slot being written.
  function automatic logic [LW-1:0] slot_of(input logic [LW-1:0] wl, input int j);
    return LW'((int'(wl) + 1 + j) % LINES);
  endfunction

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign wr_acc   = accept && !drop;

  // An accepted SOF restarts the frame before this pixel is placed.
  assign eff_col   = in_sof ? '0 : col;
  assign eff_line  = in_sof ? '0 : wr_line;
  assign eff_row   = in_sof ? '0 : row_cnt;
  assign eff_state = in_sof ? FILL : state;
  assign last_col  = (eff_col == AW'(WIDTH-1));
  assign emit      = wr_acc && (eff_state == STREAM);

  assign sram_wdata = in_data;

  always_comb begin
    sram_addr = '0;
    sram_wen  = '0;
    sram_ren  = '0;
    for (int k = 0; k < LINES; k++) begin
      for (int p = 0; p < PORTS; p++) begin
        sram_addr[k][p] = eff_col;
      end
      if (wr_acc) begin
        if (LW'(k) == eff_line) sram_wen[k][0] = 1'b1;
        else                    sram_ren[k][1] = 1'b1;
      end
    end
  end

  // Fresh read data is only on the SRAM outputs the cycle after the read; afterwards the
  // column is served from col_hold so it stays stable under backpressure.
  always_comb begin
    out_col = col_hold;
    if (rd_pending) begin
      for (int j = 0; j < LINES-1; j++) begin
        out_col[j] = sram_rdata[slot_of(wl_d, j)][1];
      end
      out_col[LINES-1] = pix_d;
    end
  end

  always_comb begin
    unused_rdata = 1'b0;
    for (int k = 0; k < LINES; k++) begin
      for (int p = 0; p < PORTS; p++) begin
        if (p != 1) unused_rdata = unused_rdata ^ (^sram_rdata[k][p]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      col        <= '0;
      wr_line    <= '0;
      row_cnt    <= '0;
      out_valid  <= 1'b0;
      rd_pending <= 1'b0;
      out_x      <= '0;
      pix_d      <= '0;
      wl_d       <= '0;
      col_hold   <= '0;
    end else begin
      rd_pending <= 1'b0;
      if (accept) begin
        out_valid  <= emit;
        rd_pending <= emit;
        if (emit) begin
          out_x <= eff_col;
          pix_d <= in_data;
          wl_d  <= eff_line;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (rd_pending) col_hold <= out_col;

      if (wr_acc) begin
        if (last_col) begin
          col     <= '0;
          wr_line <= (eff_line == LW'(LINES-1)) ? '0 : eff_line + 1'b1;
          row_cnt <= (eff_row == LW'(LINES-1)) ? eff_row : eff_row + 1'b1;
          state   <= (eff_state == FILL && eff_row == LW'(LINES-2)) ? STREAM : eff_state;
        end else begin
          col     <= eff_col + 1'b1;
          wr_line <= eff_line;
          row_cnt <= eff_row;
          state   <= eff_state;
        end
      end
    end
  end

`ifdef LB_SOF_CHECK_EN
  logic sof_seen;
  logic err_q;

  // Pixels before the first SOF of a frame are swallowed without touching the SRAM.
  assign drop    = !in_sof && !sof_seen;
  assign out_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_seen <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (in_sof) sof_seen <= 1'b1;
      if ((in_sof && col != '0) || drop) err_q <= 1'b1;
    end
  end
`else
  assign drop    = 1'b0;
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb/tb_line_buffer_ctrl.sv - directed self-checking bench for line_buffer_ctrl
module tb_line_buffer_ctrl;

  localparam int WIDTH = 4;
  localparam int BITS  = 16;
  localparam int CHAN  = 1;
  localparam int LINES = 3;
  localparam int PORTS = 2;
  localparam int AW    = $clog2(WIDTH);
  localparam int DW    = CHAN*BITS;

  typedef struct packed {
    logic [LINES-1:0][DW-1:0] col;
    logic [AW-1:0]            x;
  } col_t;

  logic                                clk = 1'b0;
  logic                                rst;
  logic                                in_valid;
  logic                                in_ready;
  logic                                in_sof;
  logic [DW-1:0]                       in_data;
  logic [LINES-1:0][PORTS-1:0][AW-1:0] sram_addr;
  logic [LINES-1:0][PORTS-1:0]         sram_wen;
  logic [LINES-1:0][PORTS-1:0]         sram_ren;
  logic [DW-1:0]                       sram_wdata;
  logic [LINES-1:0][PORTS-1:0][DW-1:0] sram_rdata;
  logic                                out_valid;
  logic                                out_ready;
  logic [LINES-1:0][DW-1:0]            out_col;
  logic [AW-1:0]                       out_x;
  logic                                out_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]    mem [LINES][WIDTH];
  col_t             colq [$];
  int               wlog [$];
  logic [LINES-1:0] rlog [$];
  col_t             mon_c;
  logic [LINES-1:0] mon_rm;

  always #5 clk = ~clk;

  line_buffer_ctrl #(
    .WIDTH(WIDTH), .BITS(BITS), .CHAN(CHAN), .LINES(LINES), .PORTS(PORTS), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_x(out_x), .out_err(out_err)
  );

  // Behavioural SRAM: read data one cycle after ren, held otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < LINES; k++) begin
      if (sram_wen[k][0]) mem[k][sram_addr[k][0]] <= sram_wdata;
      if (sram_ren[k][1]) sram_rdata[k][1] <= mem[k][sram_addr[k][1]];
      sram_rdata[k][0] <= '0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        mon_c.col = out_col;
        mon_c.x   = out_x;
        colq.push_back(mon_c);
      end
      if (|sram_wen) begin
        for (int k = 0; k < LINES; k++) begin
          if (sram_wen[k][0]) wlog.push_back(k);
          mon_rm[k] = sram_ren[k][1];
        end
        rlog.push_back(mon_rm);
      end
    end
  end

  function automatic logic [DW-1:0] pv(input int r, input int c);
    return DW'(r*16 + c);
  endfunction

  task automatic push(input logic [DW-1:0] d, input logic sof);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_rows(input int r0, input int n, input bit sof_first);
    for (int r = r0; r < r0 + n; r++)
      for (int c = 0; c < WIDTH; c++)
        push(pv(r, c), sof_first && r == r0 && c == 0);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (out_x !== '0) begin n_fail++; $display("FAIL rst_out_x got=%0d exp=0", out_x); end
    n_checks++; if (out_col !== '0) begin n_fail++; $display("FAIL rst_out_col got=%h exp=0", out_col); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rst_out_err got=%0b exp=0", out_err); end
    n_checks++; if (sram_wen !== '0 || sram_ren !== '0) begin n_fail++; $display("FAIL rst_strobes wen=%b ren=%b exp=0", sram_wen, sram_ren); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_stream();
    colq.delete();
    send_rows(0, 2, 1'b1);
    drain();
    n_checks++; if (colq.size() != 0) begin n_fail++; $display("FAIL t1_fill_cols got=%0d exp=0", colq.size()); end
    send_rows(2, 1, 1'b0);
    drain();
    n_checks++; if (colq.size() != WIDTH) begin n_fail++; $display("FAIL t1_stream_cols got=%0d exp=%0d", colq.size(), WIDTH); end
    for (int x = 0; x < WIDTH && x < colq.size(); x++) begin
      for (int j = 0; j < LINES; j++) begin
        n_checks++;
        if (colq[x].col[j] !== pv(j, x)) begin n_fail++; $display("FAIL t1_col x=%0d j=%0d got=%h exp=%h", x, j, colq[x].col[j], pv(j, x)); end
      end
      n_checks++;
      if (colq[x].x !== AW'(x)) begin n_fail++; $display("FAIL t1_out_x got=%0d exp=%0d", colq[x].x, x); end
    end
  endtask

  task automatic test_backpressure();
    logic [LINES-1:0][DW-1:0] held;
    colq.delete();
    send_rows(0, 2, 1'b1);
    push(pv(2, 0), 1'b0);
    push(pv(2, 1), 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pv(2, 2);
    in_sof    = 1'b0;
    held      = {pv(2, 1), pv(1, 1), pv(0, 1)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t2_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
      n_checks++; if (sram_wen !== '0 || sram_ren !== '0) begin n_fail++; $display("FAIL t2_strobes cyc=%0d wen=%b ren=%b exp=0", i, sram_wen, sram_ren); end
      n_checks++; if (out_valid !== 1'b1 || out_col !== held || out_x !== AW'(1)) begin
        n_fail++; $display("FAIL t2_hold cyc=%0d valid=%0b col=%h x=%0d exp valid=1 col=%h x=1", i, out_valid, out_col, out_x, held);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(pv(2, 2), 1'b0);
    push(pv(2, 3), 1'b0);
    drain();
    n_checks++; if (colq.size() != WIDTH) begin n_fail++; $display("FAIL t2_cols got=%0d exp=%0d", colq.size(), WIDTH); end
    for (int x = 0; x < WIDTH && x < colq.size(); x++) begin
      n_checks++;
      if (colq[x].x !== AW'(x) || colq[x].col !== {pv(2, x), pv(1, x), pv(0, x)}) begin
        n_fail++; $display("FAIL t2_col idx=%0d got x=%0d col=%h exp x=%0d col=%h", x, colq[x].x, colq[x].col, x, {pv(2, x), pv(1, x), pv(0, x)});
      end
    end
  endtask

  task automatic test_wrap_rotation();
    logic [LINES-1:0] exp_m;
    int r, x, ln;
    colq.delete();
    wlog.delete();
    rlog.delete();
    send_rows(0, 5, 1'b1);
    drain();
    n_checks++; if (colq.size() != 3*WIDTH) begin n_fail++; $display("FAIL t3_cols got=%0d exp=%0d", colq.size(), 3*WIDTH); end
    for (int i = 0; i < colq.size() && i < 3*WIDTH; i++) begin
      r = 2 + i / WIDTH;
      x = i % WIDTH;
      n_checks++;
      if (colq[i].x !== AW'(x) || colq[i].col !== {pv(r, x), pv(r-1, x), pv(r-2, x)}) begin
        n_fail++; $display("FAIL t3_col row=%0d x=%0d got=%h exp=%h", r, x, colq[i].col, {pv(r, x), pv(r-1, x), pv(r-2, x)});
      end
    end
    n_checks++; if (wlog.size() != 5*WIDTH) begin n_fail++; $display("FAIL t3_writes got=%0d exp=%0d", wlog.size(), 5*WIDTH); end
    for (int i = 0; i < wlog.size() && i < 5*WIDTH; i++) begin
      ln    = (i / WIDTH) % LINES;
      exp_m = '1;
      exp_m[ln] = 1'b0;
      n_checks++;
      if (wlog[i] != ln || rlog[i] !== exp_m) begin
        n_fail++; $display("FAIL t3_rotation idx=%0d wline=%0d rmask=%b exp wline=%0d rmask=%b", i, wlog[i], rlog[i], ln, exp_m);
      end
    end
  endtask

  task automatic test_mid_sof();
    logic exp_err;
`ifdef LB_SOF_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send_rows(0, 3, 1'b1);
    push(pv(3, 0), 1'b0);
    push(pv(3, 1), 1'b0);
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL t4_err_before got=%0b exp=0", out_err); end
    push(pv(0, 0), 1'b1);
    colq.delete();
    for (int c = 1; c < WIDTH; c++) push(pv(0, c), 1'b0);
    send_rows(1, 1, 1'b0);
    drain();
    n_checks++; if (colq.size() != 0) begin n_fail++; $display("FAIL t4_fill_cols got=%0d exp=0", colq.size()); end
    n_checks++; if (out_err !== exp_err) begin n_fail++; $display("FAIL t4_err got=%0b exp=%0b", out_err, exp_err); end
    send_rows(2, 1, 1'b0);
    drain();
    n_checks++; if (colq.size() != WIDTH) begin n_fail++; $display("FAIL t4_stream_cols got=%0d exp=%0d", colq.size(), WIDTH); end
    for (int x = 0; x < WIDTH && x < colq.size(); x++) begin
      n_checks++;
      if (colq[x].x !== AW'(x) || colq[x].col !== {pv(2, x), pv(1, x), pv(0, x)}) begin
        n_fail++; $display("FAIL t4_col x=%0d got=%h exp=%h", x, colq[x].col, {pv(2, x), pv(1, x), pv(0, x)});
      end
    end
  endtask

  task automatic test_reset_mid();
    send_rows(0, 2, 1'b1);
    push(pv(2, 0), 1'b0);
    push(pv(2, 1), 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t5_valid_before got=%0b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t5_valid_in_rst got=%0b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t5_ready_in_rst got=%0b exp=0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL t5_err_after_rst got=%0b exp=0", out_err); end
    colq.delete();
    send_rows(0, 3, 1'b1);
    drain();
    n_checks++; if (colq.size() != WIDTH) begin n_fail++; $display("FAIL t5_cols got=%0d exp=%0d", colq.size(), WIDTH); end
    for (int x = 0; x < WIDTH && x < colq.size(); x++) begin
      n_checks++;
      if (colq[x].x !== AW'(x) || colq[x].col !== {pv(2, x), pv(1, x), pv(0, x)}) begin
        n_fail++; $display("FAIL t5_col x=%0d got=%h exp=%h", x, colq[x].col, {pv(2, x), pv(1, x), pv(0, x)});
      end
    end
  endtask

  task automatic test_pre_sof();
    logic exp_err;
    int   exp_w;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wlog.delete();
    push(pv(0, 0), 1'b0);
    drain();
`ifdef LB_SOF_CHECK_EN
    exp_err = 1'b1;
    exp_w   = 0;
`else
    exp_err = 1'b0;
    exp_w   = 1;
`endif
    n_checks++; if (out_err !== exp_err) begin n_fail++; $display("FAIL pre_sof_err got=%0b exp=%0b", out_err, exp_err); end
    n_checks++; if (wlog.size() != exp_w) begin n_fail++; $display("FAIL pre_sof_writes got=%0d exp=%0d", wlog.size(), exp_w); end
    if (wlog.size() == 1) begin
      n_checks++; if (wlog[0] != 0) begin n_fail++; $display("FAIL pre_sof_line got=%0d exp=0", wlog[0]); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_fill_stream();
    test_backpressure();
    test_wrap_rotation();
    test_mid_sof();
    test_reset_mid();
    test_pre_sof();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
